// File: rtl/piece_spawn_ctrl.sv
// Spawn controller: pulls pieces from the tetromino generator, checks the spawn rows against the board, publishes piece/preview/game_over.
// Optional hold slot is enabled by defining HOLD_PIECE_EN.
`ifndef TETROMINO_EMPTY
`define TETROMINO_EMPTY 3'd7
`endif

package tetromino_pkg;
  localparam int COORD_W = 5;

  typedef struct packed {
    logic [2:0] data;
  } tetromino_idx_t;

  // data[r] is the 4x4 occupancy grid for rotation r, row 0 in bits [15:12].
  typedef struct packed {
    logic [3:0][15:0] data;
  } tetromino_shape_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef struct packed {
    tetromino_idx_t   idx;
    tetromino_shape_t tetromino;
    logic [1:0]       rotation;
    coord_t           coord;
  } tetromino_ctrl;

  function automatic tetromino_ctrl empty_piece();
    tetromino_ctrl p;
    p          = '0;
    p.idx.data = `TETROMINO_EMPTY;
    return p;
  endfunction
endpackage

module piece_spawn_ctrl
  import tetromino_pkg::*;
#(
  parameter int GRID_W   = 10,
  parameter int GRID_H   = 22,
  parameter int SPAWN_X  = 3,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      gen_enable,
  input  tetromino_ctrl             gen_t_in,
  input  tetromino_ctrl             gen_t_next_in,
  input  logic                      spawn_req,
  output logic                      board_rd_en,
  output logic [$clog2(GRID_H)-1:0] board_rd_row,
  input  logic [GRID_W-1:0]         board_rd_data,
  output tetromino_ctrl             piece_out,
  output logic                      piece_valid,
  output tetromino_ctrl             preview_out,
  output logic                      spawn_done,
  output logic                      game_over,
  output logic                      busy
`ifdef HOLD_PIECE_EN
  ,
  input  logic                      hold_req,
  output tetromino_ctrl             hold_out
`endif
);

  localparam int         ROW_W      = $clog2(GRID_H);
  localparam int         EXT_W      = GRID_W + SPAWN_X + 4;
  localparam logic [2:0] FIRST_DATA = 3'(READ_LAT);
  localparam logic [2:0] LAST_CNT   = 3'(3 + READ_LAT);

  typedef enum logic [2:0] {
    S_WARM, S_WARM_WAIT, S_IDLE, S_FETCH, S_LATCH, S_CHECK, S_DONE, S_OVER
  } state_t;

  state_t           state, next_state;
  logic [2:0]       cnt;
  logic             hit, hit_now, row_hit;
  logic [1:0]       data_row;
  logic [3:0]       nibble;
  logic [15:0]      shape0;
  logic [EXT_W-1:0] padded, mask;
  logic             take_hold, swap_hold;

  function automatic tetromino_ctrl respawn(input tetromino_ctrl t);
    tetromino_ctrl r;
    r          = t;
    r.rotation = '0;
    r.coord.x  = COORD_W'(SPAWN_X);
    r.coord.y  = '0;
    return r;
  endfunction

`ifdef HOLD_PIECE_EN
  logic hold_used, from_spawn, hold_empty;
  assign hold_empty = (hold_out.idx.data == `TETROMINO_EMPTY);
  assign take_hold  = (state == S_IDLE) && hold_req && !spawn_req && piece_valid && !hold_used;
  assign swap_hold  = take_hold && !hold_empty;
`else
  assign take_hold  = 1'b0;
  assign swap_hold  = 1'b0;
`endif

  // Columns past the right edge read as occupied, so a piece overhanging the board collides.
  assign padded = {{(SPAWN_X + 4){1'b1}}, board_rd_data};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_row = 2'(cnt - FIRST_DATA);
    shape0   = piece_out.tetromino.data[0];
    nibble   = shape0[3:0];
    case (data_row)
      2'd0:    nibble = shape0[15:12];
      2'd1:    nibble = shape0[11:8];
      2'd2:    nibble = shape0[7:4];
      default: nibble = shape0[3:0];
    endcase
    // Nibble bit 3 is the leftmost piece column, i.e. board column SPAWN_X.
    mask    = EXT_W'({nibble[0], nibble[1], nibble[2], nibble[3]}) << SPAWN_X;
    row_hit = |(mask & padded);
    hit_now = hit | ((state == S_CHECK) && (cnt >= FIRST_DATA) && row_hit);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WARM:      next_state = S_WARM_WAIT;
      S_WARM_WAIT: next_state = S_IDLE;
      S_IDLE: begin
        if (spawn_req)      next_state = S_FETCH;
        else if (take_hold) next_state = swap_hold ? S_CHECK : S_FETCH;
      end
      S_FETCH:     next_state = S_LATCH;
      S_LATCH:     next_state = S_CHECK;
      S_CHECK:     if (cnt == LAST_CNT) next_state = hit_now ? S_OVER : S_DONE;
      S_DONE:      next_state = S_IDLE;
      S_OVER:      next_state = S_OVER;
      default:     next_state = S_WARM;
    endcase
  end

  // NOTE: the reset state is WARM, so state-decoded strobes are qualified by rst to read 0 while reset is held.
  assign gen_enable   = rst && ((state == S_WARM) || (state == S_FETCH));
  assign busy         = rst && !((state == S_IDLE) || (state == S_OVER));
  assign board_rd_en  = (state == S_CHECK) && (cnt < 3'd4);
  assign board_rd_row = ROW_W'(cnt[1:0]);
  assign spawn_done   = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WARM;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      hit         <= 1'b0;
      piece_out   <= empty_piece();
      preview_out <= empty_piece();
      piece_valid <= 1'b0;
      game_over   <= 1'b0;
`ifdef HOLD_PIECE_EN
      hold_out    <= empty_piece();
      hold_used   <= 1'b0;
      from_spawn  <= 1'b0;
`endif
    end else begin
      if (state == S_CHECK) begin
        cnt <= cnt + 3'd1;
        hit <= hit_now;
      end
      if ((next_state == S_CHECK) && (state != S_CHECK)) begin
        cnt <= '0;
        hit <= 1'b0;
      end
      if (state == S_WARM_WAIT) preview_out <= gen_t_next_in;
      if (state == S_LATCH) begin
        piece_out   <= respawn(gen_t_in);
        preview_out <= gen_t_next_in;
      end
      if ((state == S_IDLE) && (next_state != S_IDLE)) piece_valid <= 1'b0;
      if (next_state == S_DONE) piece_valid <= 1'b1;
      if (next_state == S_OVER) game_over <= 1'b1;
`ifdef HOLD_PIECE_EN
      if ((state == S_IDLE) && spawn_req) from_spawn <= 1'b1;
      if (take_hold) begin
        from_spawn <= 1'b0;
        hold_used  <= 1'b1;
        hold_out   <= piece_out;
        if (swap_hold) piece_out <= respawn(hold_out);
      end
      if ((state == S_DONE) && from_spawn) hold_used <= 1'b0;
`endif
    end
  end

endmodule
